pipe_ctrl: RTL and testbench

Central pipeline hazard controller for the five-stage toy CPU. It generates per-stage hold signals for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the IF/ID flush. It sequences multi-cycle mul/div operations in EX with an internal state machine and down-counter. It sits beside the datapath, taking hazard inputs from ID, EX and the memory port, and driving every pipeline register's stall/flush input.

---
 rtl/pipe_ctrl_if.sv | 32 +++
 rtl/pipe_ctrl.sv | 89 ++++++++
 tb/tb_pipe_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Hazard/stall bundle between the datapath and pipe_ctrl.
// master = datapath side (drives hazards), slave = controller side.
interface pipe_ctrl_if #(
    parameter int REG_BUS = 5
);
    logic [REG_BUS-1:0] idRead1;
    logic [REG_BUS-1:0] idRead2;
    logic               idUse1;
    logic               idUse2;
    logic               idBranchTaken;
    logic               exLoad;
    logic [REG_BUS-1:0] exWriteAddr;
    logic               exMduStart;
    logic               memBusy;
    logic [4:0]         stall;
    logic               ifidFlush;
    logic               mduBusy;
    logic               mduDone;
    logic [31:0]        perfStallCnt;

    modport master (
        output idRead1, idRead2, idUse1, idUse2, idBranchTaken,
               exLoad, exWriteAddr, exMduStart, memBusy,
        input  stall, ifidFlush, mduBusy, mduDone, perfStallCnt
    );

    modport slave (
        input  idRead1, idRead2, idUse1, idUse2, idBranchTaken,
               exLoad, exWriteAddr, exMduStart, memBusy,
        output stall, ifidFlush, mduBusy, mduDone, perfStallCnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: stall/flush generation and mul/div sequencing.
// Optional stall-cycle counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    typedef enum logic {RUN, MDU} state_t;

    localparam logic [4:0] HOLD_LU  = 5'b00011;
    localparam logic [4:0] HOLD_EX  = 5'b00111;
    localparam logic [4:0] HOLD_MEM = 5'b01111;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lu;
    logic [4:0]       stall_c;
    logic             flush_c;
    logic             done_c;

    assign lu = bus.exLoad && (bus.exWriteAddr != '0) &&
                ((bus.idUse1 && (bus.idRead1 == bus.exWriteAddr)) ||
                 (bus.idUse2 && (bus.idRead2 == bus.exWriteAddr)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_c   = '0;
        flush_c   = 1'b0;
        done_c    = 1'b0;
        case (state)
            RUN: begin
                if (bus.exMduStart) begin
                    stall_c   = HOLD_EX;
                    state_nxt = MDU;
                    cnt_nxt   = CNT_W'(MDU_CYCLES - 1);
                end else if (lu) begin
                    stall_c = stall_c | HOLD_LU;
                end else if (bus.idBranchTaken && !bus.memBusy) begin
                    flush_c = 1'b1;
                end
            end
            MDU: begin
                // Terminal count waits for the memory port so the result is never dropped.
                if (cnt != '0) begin
                    stall_c = stall_c | HOLD_EX;
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (!bus.memBusy) begin
                    done_c    = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (bus.memBusy) stall_c = stall_c | HOLD_MEM;
    end

    // Outputs are forced low for the whole time reset is asserted.
    assign bus.stall     = rst ? stall_c : '0;
    assign bus.ifidFlush = rst & flush_c;
    assign bus.mduBusy   = rst & (state == MDU);
    assign bus.mduDone   = rst & done_c;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           perf_q <= '0;
        else if (stall_c[0]) perf_q <= perf_q + 32'd1;
    end

    assign bus.perfStallCnt = perf_q;
`else
    assign bus.perfStallCnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected outputs queued per cycle, popped and checked at negedge.
module tb_pipe_ctrl;
    typedef struct packed {
        logic [4:0] stall;
        logic       flush;
        logic       busy;
        logic       done;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    out_t sb[$];

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [31:0] PERF_EXP = 32'd33;
`else
    localparam logic [31:0] PERF_EXP = 32'd0;
`endif

    pipe_ctrl_if bus ();

    pipe_ctrl #(.MDU_CYCLES(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic out_t obs_now();
        return '{bus.stall, bus.ifidFlush, bus.mduBusy, bus.mduDone};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.idRead1 = '0; bus.idRead2 = '0; bus.idUse1 = 1'b0; bus.idUse2 = 1'b0;
        bus.idBranchTaken = 1'b0; bus.exLoad = 1'b0; bus.exWriteAddr = '0;
        bus.exMduStart = 1'b0; bus.memBusy = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                          input logic u2, input logic [4:0] wa);
        bus.exLoad = 1'b1; bus.idRead1 = r1; bus.idRead2 = r2;
        bus.idUse1 = u1; bus.idUse2 = u2; bus.exWriteAddr = wa;
    endtask

    // One cycle: queue expectation, compare at negedge, advance past the next posedge.
    task automatic step(input string tag, input logic [4:0] s, input logic f,
                        input logic b, input logic d);
        out_t e;
        sb.push_back('{s, f, b, d});
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk(tag, 32'(obs_now()), 32'(e));
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // Start a mul/div and step through all 32 held cycles.
    task automatic run_mdu(input string tag);
        bus.exMduStart = 1'b1;
        step({tag, "_start"}, 5'b00111, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 32; k++) begin
            bus.exMduStart = (k == 7);  // ignored while counting
            step($sformatf("%s_k%0d", tag, k), 5'b00111, 1'b0, 1'b1, 1'b0);
        end
        bus.exMduStart = 1'b0;
    endtask

    initial begin
        clr();
        bus.exMduStart = 1'b1; bus.memBusy = 1'b1; bus.idBranchTaken = 1'b1;
        set_lu(5'd5, 5'd0, 1'b1, 1'b0, 5'd5);
        #2;
        chk("reset_outs", 32'(obs_now()), 32'd0);
        chk("reset_perf", bus.perfStallCnt, 32'd0);
        @(negedge clk);
        clr();
        rst = 1'b1;
        @(posedge clk); #1;

        step("idle", 5'b00000, 1'b0, 1'b0, 1'b0);
        set_lu(5'd5, 5'd0, 1'b1, 1'b0, 5'd5);
        step("lu_src1", 5'b00011, 1'b0, 1'b0, 1'b0);
        clr();
        step("lu_clear", 5'b00000, 1'b0, 1'b0, 1'b0);
        set_lu(5'd3, 5'd9, 1'b0, 1'b1, 5'd9);
        step("lu_src2", 5'b00011, 1'b0, 1'b0, 1'b0);
        set_lu(5'd9, 5'd9, 1'b0, 1'b0, 5'd9);
        step("lu_unused", 5'b00000, 1'b0, 1'b0, 1'b0);
        set_lu(5'd0, 5'd0, 1'b1, 1'b1, 5'd0);
        step("lu_r0", 5'b00000, 1'b0, 1'b0, 1'b0);
        clr();
        bus.idBranchTaken = 1'b1;
        step("br_alone", 5'b00000, 1'b1, 1'b0, 1'b0);
        set_lu(5'd7, 5'd0, 1'b1, 1'b0, 5'd7);
        step("br_lu", 5'b00011, 1'b0, 1'b0, 1'b0);
        clr();
        bus.idBranchTaken = 1'b1; bus.memBusy = 1'b1;
        step("br_mem", 5'b01111, 1'b0, 1'b0, 1'b0);
        clr();
        bus.memBusy = 1'b1;
        step("mem_run", 5'b01111, 1'b0, 1'b0, 1'b0);
        clr();

        // Perf window: one load-use bubble plus a full mul/div.
        do_reset();
        set_lu(5'd5, 5'd0, 1'b1, 1'b0, 5'd5);
        step("perf_lu", 5'b00011, 1'b0, 1'b0, 1'b0);
        clr();
        run_mdu("mdu");
        step("mdu_done", 5'b00000, 1'b0, 1'b1, 1'b1);
        chk("perf_cnt", bus.perfStallCnt, PERF_EXP);
        step("mdu_after", 5'b00000, 1'b0, 1'b0, 1'b0);

        // Memory port busy at terminal count delays completion.
        run_mdu("mdw");
        bus.memBusy = 1'b1;
        for (int k = 0; k < 3; k++)
            step($sformatf("mdw_wait%0d", k), 5'b01111, 1'b0, 1'b1, 1'b0);
        bus.memBusy = 1'b0;
        step("mdw_done", 5'b00000, 1'b0, 1'b1, 1'b1);
        step("mdw_after", 5'b00000, 1'b0, 1'b0, 1'b0);

        // Reset while cnt==10 aborts the operation.
        do_reset();
        bus.exMduStart = 1'b1;
        step("abt_start", 5'b00111, 1'b0, 1'b0, 1'b0);
        bus.exMduStart = 1'b0;
        for (int k = 1; k < 22; k++)
            step($sformatf("abt_k%0d", k), 5'b00111, 1'b0, 1'b1, 1'b0);
        bus.memBusy = 1'b1; bus.exMduStart = 1'b1;
        rst = 1'b0;
        #1;
        chk("abt_outs", 32'(obs_now()), 32'd0);
        chk("abt_perf", bus.perfStallCnt, 32'd0);
        rst = 1'b1;
        clr();
        @(posedge clk); #1;
        step("abt_run", 5'b00000, 1'b0, 1'b0, 1'b0);
        step("abt_run2", 5'b00000, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
